iis_rx_deser: RTL and testbench
===============================

IIS_RX_DESER -- requirements
Module: iis_rx_deser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the sample word width pushed into the downstream async FIFO.
REQ-002 SHALL have parameter CNT_WIDTH, default 5, meaning the bit-counter width, with 2^CNT_WIDTH > DATA_WIDTH.
REQ-003 SHALL have port wr_clk  input  1  system clock, also the FIFO write clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  receiver enable; when low, the block returns to IDLE.
REQ-006 SHALL have port iis_sck  input  1  serial bit clock, asynchronous to wr_clk.
REQ-007 SHALL have port iis_ws  input  1  word select (0 = left, 1 = right), asynchronous.
REQ-008 SHALL have port iis_sd  input  1  serial data, MSB first, asynchronous.
REQ-009 SHALL have port full  input  1  FIFO full flag, in the wr_clk domain.
REQ-010 SHALL have port wr_en  output  1  single-cycle FIFO push strobe.
REQ-011 SHALL have port din  output  DATA_WIDTH  sample word to the FIFO; valid when wr_en=1.
REQ-012 SHALL have port word_lr  output  1  channel of the last pushed word.
REQ-013 SHALL have port clr_flags  input  1  one-cycle pulse that clears the sticky flags.
REQ-014 SHALL have port overflow  output  1  sticky flag: a word was dropped because full was high.
REQ-015 SHALL have port frame_err  output  1  sticky flag: a WS change arrived before DATA_WIDTH bits were captured.

Function
REQ-016 SHALL synchronise iis_sck, iis_ws and iis_sd through 2 flops each, and derive a one-cycle sck_rise pulse from the synchronised SCK.
REQ-017 SHALL sample WS and SD only on sck_rise cycles; wr_clk SHALL be at least 4x the SCK frequency.
REQ-018 SHALL implement states IDLE, SYNC, SHIFT and HOLD.
REQ-019 In IDLE, when en=1, the block SHALL go to SYNC.
REQ-020 In SYNC, the block SHALL wait for a sampled WS 1->0 transition, so that the first captured word is always left; it SHALL then go to SHIFT with bitcnt=0.
REQ-021 Philips timing: the MSB SHALL be sampled on the first sck_rise after the sck_rise at which the WS change is seen.
REQ-022 In SHIFT, each sck_rise SHALL shift SD into the LSB of the shift register and increment bitcnt.
REQ-023 When bitcnt reaches DATA_WIDTH, the block SHALL go to HOLD, ignore further bits (slot wider than word), and load the word and WS into the output registers.
REQ-024 wr_en SHALL pulse exactly 1 wr_clk cycle after the sck_rise cycle that captured the LSB, if full=0.
REQ-025 If full=1 at that cycle, the block SHALL drop the word, keep wr_en=0, and set overflow; it SHALL NOT retry.
REQ-026 In HOLD, a sampled WS change SHALL restart SHIFT with bitcnt=0 for the next channel.
REQ-027 In SHIFT, a WS change with bitcnt<DATA_WIDTH SHALL discard the partial word, set frame_err and return to SYNC.
REQ-028 If clr_flags and a flag set event occur in the same cycle, the set SHALL win.
REQ-029 en=0 SHALL force IDLE within 1 cycle and drop any partial word; a push already scheduled for that cycle SHALL still occur.
REQ-030 din and word_lr SHALL hold their value between pushes.

Reset
REQ-031 rst SHALL asynchronously clear the synchronisers, the shift register, bitcnt, din, word_lr, wr_en, overflow and frame_err to 0, and set the state to IDLE.
REQ-032 Deassertion of rst SHALL be synchronous to wr_clk; rst asserted mid-word SHALL produce no push.

Structure
REQ-033 A shared package SHALL hold DATA_WIDTH, CNT_WIDTH and the state enum (IDLE, SYNC, SHIFT, HOLD).
REQ-034 A sub-module iis_sync_edge SHALL contain the 2-flop synchroniser and the rising-edge detector; it SHALL be instantiated for SCK, with plain synchronisers for WS and SD.

Verification
REQ-035 Stereo stream L=16'hA5C3, R=16'h1234 at wr_clk=8xSCK -> wr_en pulses with din=A5C3/word_lr=0, then din=1234/word_lr=1, with 1-cycle latency after the LSB sck_rise.
REQ-036 Start mid-right-frame (WS=1 at en rise) -> no push until after the first WS 1->0 transition; the first pushed word is left.
REQ-037 24-bit slots carrying 24'hABCDEF -> din=16'hABCD; the remaining 8 bits are ignored.
REQ-038 full=1 during the second word -> only one push, overflow=1; clr_flags then clears overflow to 0.
REQ-039 WS toggles after 10 bits -> no push, frame_err=1, resync on the next WS 1->0.
REQ-040 rst pulse mid-word -> all outputs 0 immediately, state IDLE, and no spurious wr_en.

Source files
------------

// File: rtl/iis_rx_deser_pkg.sv
// -----------------------------------------------------------------------------
// iis_rx_deser_pkg
// Shared definitions for the I2S receive deserialiser: default sample word
// width, bit-counter width and the receiver state encoding.
// -----------------------------------------------------------------------------
package iis_rx_deser_pkg;

    // Sample word width pushed into the downstream FIFO.
    localparam int DATA_WIDTH = 16;

    // Bit-counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH so that the
    // counter can hold the value DATA_WIDTH while parked in HOLD.
    localparam int CNT_WIDTH  = 5;

    // Receiver states, with fixed encodings.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // disabled
        SYNC  = 2'd1,   // waiting for WS 1->0 (start of a left word)
        SHIFT = 2'd2,   // capturing word bits, MSB first
        HOLD  = 2'd3    // word complete, ignoring the rest of the slot
    } state_e;

endpackage

// File: rtl/iis_sync_edge.sv
// -----------------------------------------------------------------------------
// iis_sync_edge
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector on the synchronised value.
//
// Ports:
//   wr_clk  in   sampling clock
//   rst     in   asynchronous, active-high reset
//   d_i     in   asynchronous input
//   rise_o  out  one-cycle pulse on each synchronised 0->1 transition
// -----------------------------------------------------------------------------
module iis_sync_edge (
    input  logic wr_clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/iis_rx_deser.sv
// -----------------------------------------------------------------------------
// iis_rx_deser
// I2S (Philips timing) receiver. Oversamples SCK/WS/SD with wr_clk (at least
// 4x SCK), assembles DATA_WIDTH-bit words MSB first and pushes each word with
// its channel into an async FIFO through a single-cycle wr_en strobe.
//
// Ports:
//   wr_clk     in   system clock, also the FIFO write clock
//   rst        in   asynchronous, active-high reset
//   en         in   receiver enable; low returns the receiver to IDLE
//   iis_sck    in   serial bit clock (asynchronous)
//   iis_ws     in   word select, 0 = left, 1 = right (asynchronous)
//   iis_sd     in   serial data, MSB first (asynchronous)
//   full       in   FIFO full flag (wr_clk domain)
//   wr_en      out  FIFO push strobe
//   din        out  sample word, valid while wr_en = 1, held between pushes
//   word_lr    out  channel of the last loaded word
//   clr_flags  in   one-cycle pulse clearing the sticky flags
//   overflow   out  sticky: a word was dropped because full was high
//   frame_err  out  sticky: WS changed before a word was complete
// -----------------------------------------------------------------------------
module iis_rx_deser #(
    parameter int DATA_WIDTH = iis_rx_deser_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = iis_rx_deser_pkg::CNT_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  iis_sck,
    input  logic                  iis_ws,
    input  logic                  iis_sd,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  word_lr,
    input  logic                  clr_flags,
    output logic                  overflow,
    output logic                  frame_err
);

    import iis_rx_deser_pkg::*;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    // Reset is applied asynchronously but released only after two wr_clk
    // edges, so no flop leaves reset on an arbitrary edge.
    logic rst_meta_q;
    logic rst_int_q;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_int_q  <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_int_q  <= rst_meta_q;
        end
    end

    // SCK gets an edge detector; WS and SD only need plain synchronisers.
    // All three pass through two flops, so ws_s/sd_s line up with sck_rise.
    logic       sck_rise;
    logic [1:0] ws_sync_q;
    logic [1:0] sd_sync_q;
    logic       ws_s;
    logic       sd_s;

    iis_sync_edge u_sck_sync (
        .wr_clk (wr_clk),
        .rst    (rst_int_q),
        .d_i    (iis_sck),
        .rise_o (sck_rise)
    );

    always_ff @(posedge wr_clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            ws_sync_q <= 2'b00;
            sd_sync_q <= 2'b00;
        end else begin
            ws_sync_q <= {ws_sync_q[0], iis_ws};
            sd_sync_q <= {sd_sync_q[0], iis_sd};
        end
    end

    assign ws_s = ws_sync_q[1];
    assign sd_s = sd_sync_q[1];

    // Receiver state.
    state_e                 state_q,     state_d;
    logic [CNT_WIDTH-1:0]   bitcnt_q,    bitcnt_d;
    logic [DATA_WIDTH-1:0]  shreg_q,     shreg_d;
    logic                   ch_q,        ch_d;
    logic [DATA_WIDTH-1:0]  din_q,       din_d;
    logic                   word_lr_q,   word_lr_d;
    logic                   push_q,      push_d;
    logic                   overflow_q,  overflow_d;
    logic                   frame_err_q, frame_err_d;
    logic                   ws_last_q;
    logic                   ws_change;
    logic                   ovf_set;
    logic                   ferr_set;

    // WS as seen on the previous sck_rise; a change is only meaningful on a
    // sck_rise cycle.
    assign ws_change = sck_rise & (ws_s != ws_last_q);

    // The push is decided against full in the cycle the strobe is presented.
    assign ovf_set = push_q & full;

    // NOTE: every signal assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        ch_d      = ch_q;
        din_d     = din_q;
        word_lr_d = word_lr_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) state_d = SYNC;
            end
            SYNC: begin
                // Only a 1->0 edge starts capture, so the first word is left.
                if (sck_rise && ws_last_q && !ws_s) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    ch_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], sd_s};
                    if (bitcnt_q == LAST_BIT) begin
                        // LSB: load outputs. With a slot exactly DATA_WIDTH
                        // wide, WS already flips on this bit for the next
                        // channel, so that is a restart, not a frame error.
                        din_d     = {shreg_q[DATA_WIDTH-2:0], sd_s};
                        word_lr_d = ch_q;
                        push_d    = 1'b1;
                        if (ws_change) begin
                            state_d  = SHIFT;
                            bitcnt_d = '0;
                            ch_d     = ws_s;
                        end else begin
                            state_d  = HOLD;
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end else if (ws_change) begin
                        ferr_set = 1'b1;
                        state_d  = SYNC;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ws_change) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    ch_d     = ws_s;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything except an already scheduled push.
        if (!en) begin
            state_d  = IDLE;
            bitcnt_d = '0;
        end

        // Set wins over a simultaneous clear.
        overflow_d  = (overflow_q  & ~clr_flags) | ovf_set;
        frame_err_d = (frame_err_q & ~clr_flags) | ferr_set;
    end

    always_ff @(posedge wr_clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            ch_q        <= 1'b0;
            din_q       <= '0;
            word_lr_q   <= 1'b0;
            push_q      <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ws_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            ch_q        <= ch_d;
            din_q       <= din_d;
            word_lr_q   <= word_lr_d;
            push_q      <= push_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            if (sck_rise) ws_last_q <= ws_s;
        end
    end

    assign wr_en     = push_q & ~full;
    assign din       = din_q;
    assign word_lr   = word_lr_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_iis_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_iis_rx_deser
// Directed bench for iis_rx_deser: I2S streams at wr_clk = 8x SCK, built bit
// by bit (Philips timing: WS flips one bit before the MSB) and replayed, with
// pushes captured by a monitor and compared against hand-computed words.
// -----------------------------------------------------------------------------
module tb_iis_rx_deser;

    localparam int DW = 16;

    logic          wr_clk = 1'b0;
    logic          rst    = 1'b1;
    logic          en     = 1'b0;
    logic          iis_sck = 1'b0;
    logic          iis_ws  = 1'b1;
    logic          iis_sd  = 1'b0;
    logic          full    = 1'b0;
    logic          clr_flags = 1'b0;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          word_lr;
    logic          overflow;
    logic          frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    iis_rx_deser dut (
        .wr_clk    (wr_clk),
        .rst       (rst),
        .en        (en),
        .iis_sck   (iis_sck),
        .iis_ws    (iis_ws),
        .iis_sd    (iis_sd),
        .full      (full),
        .wr_en     (wr_en),
        .din       (din),
        .word_lr   (word_lr),
        .clr_flags (clr_flags),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 wr_clk = ~wr_clk;
    always @(posedge wr_clk) cyc <= cyc + 1;

    // ---------------- push monitor ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          lr;
        int            c;
    } push_t;

    push_t pushes[$];
    int    dbl_pulse = 0;
    logic  wr_en_prev = 1'b0;

    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) pushes.push_back('{din, word_lr, cyc});
        if (wr_en === 1'b1 && wr_en_prev === 1'b1) dbl_pulse++;
        wr_en_prev = wr_en;
    end

    function automatic push_t get_push(int i);
        push_t p;
        p.d  = 'x;
        p.lr = 1'bx;
        p.c  = -1000;
        if (i < pushes.size()) p = pushes[i];
        return p;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- serial stream builder ----------------
    typedef struct packed {
        logic ws;
        logic sd;
    } bit_t;

    bit_t bits[$];
    int   rise_cyc[$];

    // n bits of channel ch, taken MSB first from left-justified data.
    task automatic add_run(logic ch, int n, logic [31:0] data);
        for (int j = 0; j < n; j++) bits.push_back('{ch, data[31-j]});
    endtask

    // A full slot: WS flips to next_ch on the slot's last bit.
    task automatic add_slot(logic ch, logic next_ch, logic [31:0] data, int slot);
        for (int j = 0; j < slot; j++)
            bits.push_back('{(j == slot - 1) ? next_ch : ch, data[31-j]});
    endtask

    // Right-channel lead-in of len bits ending in the WS 1->0 flip.
    task automatic add_preamble(int len);
        add_run(1'b1, len - 1, 32'hDEAD_BEEF);
        add_run(1'b0, 1, 32'h8000_0000);
    endtask

    // 8 wr_clk cycles per bit: 4 low (data/WS change), 4 high.
    task automatic play();
        rise_cyc.delete();
        foreach (bits[i]) begin
            @(negedge wr_clk);
            iis_sck = 1'b0;
            iis_ws  = bits[i].ws;
            iis_sd  = bits[i].sd;
            repeat (3) @(negedge wr_clk);
            iis_sck = 1'b1;
            rise_cyc.push_back(cyc);
            repeat (3) @(negedge wr_clk);
        end
        bits.delete();
    endtask

    task automatic start_test();
        rst = 1'b1; en = 1'b0; full = 1'b0; clr_flags = 1'b0;
        iis_sck = 1'b0; iis_ws = 1'b1; iis_sd = 1'b0;
        repeat (2) @(negedge wr_clk);
        rst = 1'b0;
        repeat (4) @(negedge wr_clk);
        en = 1'b1;
        pushes.delete();
        dbl_pulse = 0;
        @(negedge wr_clk);
    endtask

    task automatic pulse_clr();
        @(negedge wr_clk); clr_flags = 1'b1;
        @(negedge wr_clk); clr_flags = 1'b0;
        @(negedge wr_clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        int            pre_len;
        int            slot;
        logic [31:0]   l_bits;
        logic [31:0]   r_bits;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    initial begin
        push_t p0, p1;
        int    lsb_r;

        vecs[0] = '{"std16",    16, 16, 32'hA5C3_0000, 32'h1234_0000, 16'hA5C3, 16'h1234};
        vecs[1] = '{"slot24",   24, 24, 32'hABCD_EF00, 32'h1357_9B00, 16'hABCD, 16'h1357};
        vecs[2] = '{"ones_one", 16, 16, 32'hFFFF_0000, 32'h0001_0000, 16'hFFFF, 16'h0001};
        vecs[3] = '{"slot32",   32, 32, 32'h8001_5555, 32'h7FFE_AAAA, 16'h8001, 16'h7FFE};
        vecs[4] = '{"midright",  5, 16, 32'hC3A5_0000, 32'h0FF0_0000, 16'hC3A5, 16'h0FF0};

        // Reset state.
        repeat (2) @(negedge wr_clk);
        check("rst_wr_en",     32'(wr_en),     32'h0);
        check("rst_din",       32'(din),       32'h0);
        check("rst_word_lr",   32'(word_lr),   32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // Stereo streams: left then right, trailing partial left word.
        foreach (vecs[v]) begin
            start_test();
            add_preamble(vecs[v].pre_len);
            add_slot(1'b0, 1'b1, vecs[v].l_bits, vecs[v].slot);
            add_slot(1'b1, 1'b0, vecs[v].r_bits, vecs[v].slot);
            add_run(1'b0, 4, 32'hF000_0000);
            play();
            repeat (4) @(negedge wr_clk);
            p0 = get_push(0);
            p1 = get_push(1);
            check({vecs[v].name, "_count"},   32'(pushes.size()), 32'd2);
            check({vecs[v].name, "_l_din"},   32'(p0.d),  32'(vecs[v].exp_l));
            check({vecs[v].name, "_l_lr"},    32'(p0.lr), 32'h0);
            check({vecs[v].name, "_r_din"},   32'(p1.d),  32'(vecs[v].exp_r));
            check({vecs[v].name, "_r_lr"},    32'(p1.lr), 32'h1);
            check({vecs[v].name, "_latency"},
                  32'(p0.c - rise_cyc[vecs[v].pre_len + DW - 1]), 32'd3);
            check({vecs[v].name, "_single"},  32'(dbl_pulse), 32'd0);
            check({vecs[v].name, "_hold_din"}, 32'(din),     32'(vecs[v].exp_r));
            check({vecs[v].name, "_hold_lr"},  32'(word_lr), 32'h1);
            check({vecs[v].name, "_flags"},   32'({overflow, frame_err}), 32'h0);
        end

        // Full during the right word, with clr_flags on the drop cycle.
        start_test();
        add_preamble(16);
        add_slot(1'b0, 1'b1, 32'hA5C3_0000, 16);
        add_slot(1'b1, 1'b0, 32'h1234_0000, 16);
        add_run(1'b0, 4, 32'hF000_0000);
        lsb_r = 16 + 16 + DW - 1;
        fork
            play();
            begin
                for (int k = 0; k < 4000 && pushes.size() == 0; k++) @(negedge wr_clk);
                check("full_first_push_seen", 32'(pushes.size() > 0), 32'h1);
                full = 1'b1;
                for (int k = 0; k < 4000 && rise_cyc.size() <= lsb_r; k++) @(negedge wr_clk);
                check("full_lsb_seen", 32'(rise_cyc.size() > lsb_r), 32'h1);
                if (rise_cyc.size() > lsb_r) begin
                    for (int k = 0; k < 20 && cyc != rise_cyc[lsb_r] + 3; k++) @(negedge wr_clk);
                    clr_flags = 1'b1;
                    @(negedge wr_clk);
                    clr_flags = 1'b0;
                end
            end
        join
        repeat (2) @(negedge wr_clk);
        full = 1'b0;
        p0 = get_push(0);
        check("full_count",    32'(pushes.size()), 32'd1);
        check("full_first",    32'(p0.d),     32'hA5C3);
        check("full_set_wins", 32'(overflow), 32'h1);
        pulse_clr();
        check("full_cleared",  32'(overflow), 32'h0);

        // WS toggles after 10 bits of a left word.
        start_test();
        add_preamble(16);
        add_run(1'b0, 10, 32'hFFC0_0000);
        add_slot(1'b1, 1'b0, 32'h5555_0000, 16);
        add_slot(1'b0, 1'b1, 32'h0F0F_0000, 16);
        add_run(1'b1, 4, 32'hF000_0000);
        play();
        repeat (4) @(negedge wr_clk);
        p0 = get_push(0);
        check("ferr_count", 32'(pushes.size()), 32'd1);
        check("ferr_din",   32'(p0.d),      32'h0F0F);
        check("ferr_lr",    32'(p0.lr),     32'h0);
        check("ferr_flag",  32'(frame_err), 32'h1);
        check("ferr_ovf",   32'(overflow),  32'h0);
        pulse_clr();
        check("ferr_cleared", 32'(frame_err), 32'h0);

        // Reset mid-word after two pushes and a frame error.
        start_test();
        add_preamble(16);
        add_slot(1'b0, 1'b1, 32'hA5C3_0000, 16);
        add_slot(1'b1, 1'b0, 32'h1234_0000, 16);
        add_run(1'b0, 6, 32'hA800_0000);
        add_slot(1'b1, 1'b0, 32'h0000_0000, 16);
        add_run(1'b0, 8, 32'hFF00_0000);
        play();
        check("prerst_count", 32'(pushes.size()), 32'd2);
        check("prerst_ferr",  32'(frame_err), 32'h1);
        check("prerst_din",   32'(din),       32'h1234);
        @(negedge wr_clk);
        rst = 1'b1;
        #1;
        check("midrst_wr_en",     32'(wr_en),     32'h0);
        check("midrst_din",       32'(din),       32'h0);
        check("midrst_word_lr",   32'(word_lr),   32'h0);
        check("midrst_overflow",  32'(overflow),  32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        repeat (2) @(negedge wr_clk);
        rst = 1'b0;
        repeat (4) @(negedge wr_clk);
        add_run(1'b0, 8, 32'h00FF_0000);
        add_slot(1'b1, 1'b1, 32'hFFFF_0000, 16);
        play();
        repeat (4) @(negedge wr_clk);
        check("postrst_count", 32'(pushes.size()), 32'd2);
        check("postrst_ferr",  32'(frame_err), 32'h0);
        check("postrst_din",   32'(din),       32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
